seg_scan_ctrl: RTL

Parametrised, time-multiplexed seven-segment display controller. It takes a packed vector of hex digits and drives a common-anode display of NUM_DIGITS digits by scanning one digit per refresh slot. Each frame takes a tear-free snapshot of the digits, decodes hex to active-low segments, and provides per-digit blanking, decimal points, leading-zero suppression and anti-ghosting dead time. It sits between the datapath (counters and registers to display) and the board's AN/CA..CG/DP pins.

---
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner: per-frame snapshot of
// the hex digits, hex decode, leading-zero suppression and anode dead time.

module seg_scan_lane (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] pat
);
  // Active-low gfedcba patterns.
  always_comb begin
    pat = 7'h7F;
    if (!blank) begin
      unique case (nib)
        4'h0: pat = 7'h40;
        4'h1: pat = 7'h79;
        4'h2: pat = 7'h24;
        4'h3: pat = 7'h30;
        4'h4: pat = 7'h19;
        4'h5: pat = 7'h12;
        4'h6: pat = 7'h02;
        4'h7: pat = 7'h78;
        4'h8: pat = 7'h00;
        4'h9: pat = 7'h10;
        4'hA: pat = 7'h08;
        4'hB: pat = 7'h03;
        4'hC: pat = 7'h46;
        4'hD: pat = 7'h21;
        4'hE: pat = 7'h06;
        4'hF: pat = 7'h0E;
        default: pat = 7'h7F;
      endcase
    end
  end
endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          lz_en,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          seg_dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] DEAD     = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  logic [NUM_DIGITS-1:0][3:0] snap_dig;
  logic [NUM_DIGITS-1:0]      snap_dp;
  logic [NUM_DIGITS-1:0]      snap_en;
  logic                       snap_lz;

  logic [NUM_DIGITS-1:0][6:0] pat;
  logic [NUM_DIGITS-1:0]      supp;
  logic [NUM_DIGITS-1:0]      onehot;
  logic                       slot_end, frame_end, in_dead;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign in_dead   = (cnt < DEAD);

  // Digit i blanks when it and every more-significant digit is zero.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    if (i == 0) begin : g_lsd
      assign supp[i] = 1'b0;
    end else begin : g_upper
      assign supp[i] = snap_lz && (snap_dig[NUM_DIGITS-1:i] == '0);
    end
    seg_scan_lane u_lane (
      .nib   (snap_dig[i]),
      .blank (supp[i]),
      .pat   (pat[i])
    );
  end

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      snap_dig   <= '0;
      snap_dp    <= '0;
      snap_en    <= '0;
      snap_lz    <= 1'b0;
      an         <= '1;
      seg        <= 7'h7F;
      seg_dp     <= 1'b1;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Snapshot only at the frame boundary so a frame never mixes old/new data.
      if (frame_end) begin
        snap_dig <= digits;
        snap_dp  <= dp;
        snap_en  <= digit_en;
        snap_lz  <= lz_en;
      end

      digit_idx  <= idx;
      frame_done <= (cnt == '0) && (idx == '0);

      if (in_dead || !snap_en[idx]) begin
        an     <= '1;
        seg    <= 7'h7F;
        seg_dp <= 1'b1;
      end else begin
        an     <= ~onehot;
        seg    <= pat[idx];
        seg_dp <= ~snap_dp[idx];
      end
    end
  end
endmodule
